rom_arbiter: RTL

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// Two-port round-robin burst reader in front of a registered single-port ROM.
// A winning requester gets a one-cycle grant, then its burst is issued to the
// ROM one address per cycle (wrapping mod 8); read data returns one cycle later.
module rom_arbiter #(
    parameter int unsigned data_width = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [2:0]            addr0,
    input  logic [2:0]            addr1,
    input  logic [2:0]            len0,
    input  logic [2:0]            len1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [data_width-1:0] rdata,
    output logic                  done0,
    output logic                  done1,
    output logic                  rom_en,
    output logic [2:0]            rom_addr,
    input  logic [data_width-1:0] rom_data
);

    localparam int unsigned AW = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_ptr;
    logic            r_owner;
    logic [AW-1:0]   r_cur_addr;
    logic [AW-1:0]   r_cnt;
    logic            r_gnt0;
    logic            r_gnt1;
    logic            r_rvalid0;
    logic            r_rvalid1;
    logic            r_done0;
    logic            r_done1;

    state_t          w_state;
    logic            w_ptr;
    logic            w_owner;
    logic [AW-1:0]   w_cur_addr;
    logic [AW-1:0]   w_cnt;
    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_rvalid0;
    logic            w_rvalid1;
    logic            w_done0;
    logic            w_done1;
    logic            w_win;
    logic            w_rom_en;

    assign w_rom_en = (r_state == ISSUE);

    // Next-state, arbitration and response-pipeline computation.
    always_comb begin
        w_state    = r_state;
        w_ptr      = r_ptr;
        w_owner    = r_owner;
        w_cur_addr = r_cur_addr;
        w_cnt      = r_cnt;
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        // Pointer decides only on contention; a lone requester always wins.
        w_win      = (req0 && req1) ? r_ptr : req1;
        // Read data for this cycle's ROM access appears one cycle later.
        w_rvalid0  = w_rom_en && !r_owner;
        w_rvalid1  = w_rom_en && r_owner;
        w_done0    = w_rvalid0 && (r_cnt == '0);
        w_done1    = w_rvalid1 && (r_cnt == '0);

        case (r_state)
            IDLE: begin
                if (req0 || req1) begin
                    w_state    = ISSUE;
                    w_owner    = w_win;
                    w_cur_addr = w_win ? addr1 : addr0;
                    w_cnt      = w_win ? len1 : len0;
                    w_gnt0     = !w_win;
                    w_gnt1     = w_win;
                    if (w_win == r_ptr) begin
                        w_ptr = !r_ptr;
                    end
                end
            end
            ISSUE: begin
                w_cur_addr = r_cur_addr + AW'(1);
                w_cnt      = r_cnt - AW'(1);
                if (r_cnt == '0) begin
                    w_state = WAIT;
                end
            end
            WAIT: begin
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_cur_addr <= '0;
            r_cnt      <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_ptr      <= w_ptr;
            r_owner    <= w_owner;
            r_cur_addr <= w_cur_addr;
            r_cnt      <= w_cnt;
            r_gnt0     <= w_gnt0;
            r_gnt1     <= w_gnt1;
            r_rvalid0  <= w_rvalid0;
            r_rvalid1  <= w_rvalid1;
            r_done0    <= w_done0;
            r_done1    <= w_done1;
        end
    end

    assign gnt0     = r_gnt0;
    assign gnt1     = r_gnt1;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign done0    = r_done0;
    assign done1    = r_done1;
    assign rom_en   = w_rom_en;
    assign rom_addr = w_rom_en ? r_cur_addr : '0;
    assign rdata    = rom_data;

endmodule
